// File: rtl/ysyx_23060187_regfile_sb.sv
// ysyx_23060187_regfile_sb: register file with per-register pending-write
// scoreboard for the pipelined NPC core. x0 reads as zero and ignores writes.
// Optional macro YSYX_23060187_RF_BYPASS_EN enables same-cycle write-through
// forwarding on the read ports (the debug port is never forwarded).
module ysyx_23060187_regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned PEND_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    output logic                        issue_ready,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic [ADDR_WIDTH-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0]       dbg_data,
    output logic                        err_underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf   [DEPTH];
    logic [PEND_WIDTH-1:0] pend [DEPTH];
    logic                  err;

    logic             issue_acc;
    logic             wb_valid;
    logic             underflow;
    logic [DEPTH-1:0] inc_vec;
    logic [DEPTH-1:0] dec_vec;

    // Issue stalls only when the destination counter is saturated; wen is
    // deliberately not considered so decode sees no path through writeback.
    assign issue_ready   = !((issue_rd != '0) && (pend[issue_rd] == '1));
    assign issue_acc     = issue_valid && issue_ready;
    assign wb_valid      = wen && (waddr != '0);
    assign underflow     = wb_valid && (pend[waddr] == '0);
    assign err_underflow = err;
    assign dbg_data      = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    // One-hot increment/decrement requests per register (x0 excluded).
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_acc && (issue_rd != '0)) inc_vec[issue_rd] = 1'b1;
        if (wb_valid)                      dec_vec[waddr]    = 1'b1;
    end

    // Architectural data, pending counters and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[i]   <= '0;
                pend[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_valid) rf[waddr] <= wdata;
            if (underflow) err <= 1'b1;
            for (int unsigned r = 1; r < DEPTH; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10: pend[r] <= pend[r] + PEND_WIDTH'(1);
                    2'b01: if (pend[r] != '0) pend[r] <= pend[r] - PEND_WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

    // Combinational read ports with optional write-through forwarding.
    always_comb begin : read_ports
        logic [ADDR_WIDTH-1:0] ra;
        ra    = '0;
        rdata = '0;
        rbusy = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (ra != '0) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
                rbusy[k] = (pend[ra] != '0);
`ifdef YSYX_23060187_RF_BYPASS_EN
                if (wen && (waddr == ra)) begin
                    rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
                    // The last outstanding write completes now unless a new
                    // producer to the same register is being issued alongside.
                    if ((pend[ra] == PEND_WIDTH'(1)) && !(issue_acc && (issue_rd == ra)))
                        rbusy[k] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_regfile_sb.sv
// Directed testbench for ysyx_23060187_regfile_sb (default parameters).
module tb_ysyx_23060187_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        err_underflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ysyx_23060187_regfile_sb #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .NREAD(2),
        .PEND_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata),
        .rbusy(rbusy),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; single-cycle controls drop right after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wen         = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; wen = 1'b0;
        waddr = '0; wdata = '0; raddr = '0; dbg_addr = '0;
        #2;
        check("reset_rdata", {32'b0, rdata}, 64'h0);
        check("reset_rbusy", {62'b0, rbusy}, 64'h0);
        check("reset_ready", {63'b0, issue_ready}, 64'h1);
        check("reset_err",   {63'b0, err_underflow}, 64'h0);
        #10 rst_n = 1'b1;
        tick();

        // Async reset mid-operation clears data and pending state at once.
        raddr[4:0] = 5'd5; dbg_addr = 5'd5;
        issue(5'd5); tick();
        wb(5'd5, 32'hDEADBEEF); tick();
        issue(5'd5); tick();
        check("x5_data",  {32'b0, rdata[31:0]}, 64'hDEADBEEF);
        check("x5_dbg",   {32'b0, dbg_data}, 64'hDEADBEEF);
        check("x5_busy",  {63'b0, rbusy[0]}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rdata", {32'b0, rdata[31:0]}, 64'h0);
        check("arst_rbusy", {62'b0, rbusy}, 64'h0);
        check("arst_ready", {63'b0, issue_ready}, 64'h1);
        check("arst_dbg",   {32'b0, dbg_data}, 64'h0);
        check("arst_err",   {63'b0, err_underflow}, 64'h0);
        #1 rst_n = 1'b1;
        tick();

        // x0: writes and issues have no effect, no underflow.
        raddr[4:0] = 5'd0; dbg_addr = 5'd0;
        wb(5'd0, 32'h1234); issue(5'd0);
        #1 check("x0_ready", {63'b0, issue_ready}, 64'h1);
        tick();
        check("x0_rdata", {32'b0, rdata[31:0]}, 64'h0);
        check("x0_rbusy", {63'b0, rbusy[0]}, 64'h0);
        check("x0_dbg",   {32'b0, dbg_data}, 64'h0);
        check("x0_err",   {63'b0, err_underflow}, 64'h0);

        // Saturation of x3's counter.
        raddr[4:0] = 5'd3;
        issue(5'd3); tick();
        check("sat1_busy",  {63'b0, rbusy[0]}, 64'h1);
        check("sat1_ready", {63'b0, issue_ready}, 64'h1);
        issue(5'd3); tick();
        issue(5'd3); tick();
        check("sat3_busy",  {63'b0, rbusy[0]}, 64'h1);
        check("sat3_ready", {63'b0, issue_ready}, 64'h0);
        issue(5'd3); tick();                 // refused: counter must stay 3
        check("sat4_ready", {63'b0, issue_ready}, 64'h0);
        wb(5'd3, 32'h11); tick();
        check("sat_wb1_ready", {63'b0, issue_ready}, 64'h1);
        check("sat_wb1_busy",  {63'b0, rbusy[0]}, 64'h1);
        check("sat_wb1_data",  {32'b0, rdata[31:0]}, 64'h11);
        wb(5'd3, 32'h22); tick();
        check("sat_wb2_busy",  {63'b0, rbusy[0]}, 64'h1);
        wb(5'd3, 32'h33);
        #1;
`ifdef YSYX_23060187_RF_BYPASS_EN
        check("sat_wb3_same_data", {32'b0, rdata[31:0]}, 64'h33);
        check("sat_wb3_same_busy", {63'b0, rbusy[0]}, 64'h0);
`else
        check("sat_wb3_same_data", {32'b0, rdata[31:0]}, 64'h22);
        check("sat_wb3_same_busy", {63'b0, rbusy[0]}, 64'h1);
`endif
        tick();
        check("sat_wb3_busy", {63'b0, rbusy[0]}, 64'h0);
        check("sat_wb3_data", {32'b0, rdata[31:0]}, 64'h33);

        // Simultaneous issue and writeback to x7 with pend == 1.
        raddr[9:5] = 5'd7;
        issue(5'd7); tick();
        issue(5'd7); wb(5'd7, 32'h77);
        #1 check("x7_same_busy", {63'b0, rbusy[1]}, 64'h1);
        tick();
        check("x7_sim_busy", {63'b0, rbusy[1]}, 64'h1);
        check("x7_sim_data", {32'b0, rdata[63:32]}, 64'h77);
        wb(5'd7, 32'hA5); tick();
        check("x7_busy", {63'b0, rbusy[1]}, 64'h0);
        check("x7_data", {32'b0, rdata[63:32]}, 64'hA5);
        check("x3_port0", {32'b0, rdata[31:0]}, 64'h33);

        // Same-cycle visibility of a writeback to x9; debug never bypassed.
        raddr[9:5] = 5'd9; dbg_addr = 5'd9;
        issue(5'd9); tick();
        wb(5'd9, 32'h99); tick();
        issue(5'd9); tick();
        wb(5'd9, 32'hCAFE0001);
        #1;
`ifdef YSYX_23060187_RF_BYPASS_EN
        check("byp_data", {32'b0, rdata[63:32]}, 64'hCAFE0001);
        check("byp_busy", {63'b0, rbusy[1]}, 64'h0);
`else
        check("byp_data", {32'b0, rdata[63:32]}, 64'h99);
        check("byp_busy", {63'b0, rbusy[1]}, 64'h1);
`endif
        check("byp_dbg", {32'b0, dbg_data}, 64'h99);
        tick();
        check("x9_data", {32'b0, rdata[63:32]}, 64'hCAFE0001);
        check("x9_busy", {63'b0, rbusy[1]}, 64'h0);
        check("x9_dbg",  {32'b0, dbg_data}, 64'hCAFE0001);
        check("no_err_yet", {63'b0, err_underflow}, 64'h0);

        // Underflow is sticky until reset.
        raddr[4:0] = 5'd12;
        wb(5'd12, 32'h5); tick();
        check("uf_err",  {63'b0, err_underflow}, 64'h1);
        check("uf_data", {32'b0, rdata[31:0]}, 64'h5);
        check("uf_busy", {63'b0, rbusy[0]}, 64'h0);
        issue(5'd12); tick();
        wb(5'd12, 32'h6); tick();
        check("uf_sticky", {63'b0, err_underflow}, 64'h1);
        check("uf_data2",  {32'b0, rdata[31:0]}, 64'h6);
        #1 rst_n = 1'b0;
        #1;
        check("uf_clear", {63'b0, err_underflow}, 64'h0);
        check("uf_rst_data", {32'b0, rdata[31:0]}, 64'h0);
        #1 rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
